// File: rtl/echo_ranger.sv
// ---------------------------------------------------------------------------
// echo_ranger
//
// HC-SR04-style ultrasonic ranging front-end. Once per PERIOD_CYCLES it fires
// a TRIG_CYCLES-wide trigger pulse, times the high phase of the returned echo
// and reports the width as whole millimetres (echo_high_cycles / MM_TICKS,
// computed with a prescaler rather than a divider), saturating at 4095.
// A missing echo, or one that never falls, reads as 4095 with no_echo set.
//
// Optional feature (compile-time macro ECHO_RANGER_MEDIAN_EN):
//   defined   - raw results enter a 3-deep history (reset to 4095) and the
//               reported distance is the registered median of the history;
//               dst_valid is delayed one cycle to match.
//   undefined - the raw result is reported directly.
//
// Ports:
//   clk        in   system clock (50 MHz nominal)
//   rst        in   synchronous, active-high reset
//   echo       in   asynchronous sensor echo line
//   trig       out  sensor trigger
//   binary_dst out  [11:0] distance in mm, 4095 = out of range / no echo
//   dst_valid  out  one-cycle strobe when binary_dst updates
//   no_echo    out  last raw measurement timed out
// ---------------------------------------------------------------------------
module echo_ranger #(
  parameter int TRIG_CYCLES   = 500,
  parameter int MM_TICKS      = 291,
  parameter int ECHO_TIMEOUT  = 1250000,
  parameter int PERIOD_CYCLES = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] binary_dst,
  output logic        dst_valid,
  output logic        no_echo
);

  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam int TRG_W = $clog2(TRIG_CYCLES + 1);
  localparam int TMO_W = $clog2(ECHO_TIMEOUT + 1);
  localparam int PRE_W = $clog2(MM_TICKS + 1);

  localparam logic [11:0]      DST_MAX  = 12'hFFF;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ECHO_TIMEOUT - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MM_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    TIMEOUT   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic             echo_p0, echo_p1, echo_p2;
  logic             echo_s, rise, fall;
  logic [PER_W-1:0] per_cnt;
  logic [TRG_W-1:0] trg_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [11:0]      mm_cnt;
  logic             tmo_hit;
  logic             cnt_clr, tmo_run, tick_en, meas_go, tmo_go;
  logic [11:0]      res_new;
  logic             vld_p0;

  function automatic logic [11:0] mm_sat_inc(input logic [11:0] v);
    return (v == DST_MAX) ? v : v + 12'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser; echo_p2 holds the previous echo_s
  // for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_p0 <= 1'b0;
      echo_p1 <= 1'b0;
      echo_p2 <= 1'b0;
    end else begin
      echo_p0 <= echo;
      echo_p1 <= echo_p0;
      echo_p2 <= echo_p1;
    end
  end

  assign echo_s = echo_p1;
  assign rise   = echo_s & ~echo_p2;
  assign fall   = ~echo_s & echo_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  // The timeout counter holds the number of cycles spent since TRIG exit, so
  // TMO_LAST is the last cycle before ECHO_TIMEOUT is reached.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    tmo_run   = 1'b0;
    tick_en   = 1'b0;
    meas_go   = 1'b0;
    tmo_go    = 1'b0;
    case (state)
      IDLE: begin
        if (per_cnt == '0) state_nxt = TRIG;
      end
      TRIG: begin
        if (trg_cnt == TRG_LAST) begin
          state_nxt = WAIT_RISE;
          cnt_clr   = 1'b1;
        end
      end
      WAIT_RISE: begin
        tmo_run = 1'b1;
        if (tmo_hit) begin
          state_nxt = TIMEOUT;
          tmo_go    = 1'b1;
        end else if (rise) begin
          // The edge cycle already has echo_s high, so it is counted here.
          state_nxt = MEASURE;
          tick_en   = 1'b1;
        end
      end
      MEASURE: begin
        tmo_run = 1'b1;
        if (tmo_hit) begin
          state_nxt = TIMEOUT;
          tmo_go    = 1'b1;
        end else begin
          tick_en = echo_s;
          if (fall) begin
            state_nxt = DONE;
            meas_go   = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      TIMEOUT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trigger also drops combinationally while rst is held.
  assign trig = (state == TRIG) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      trg_cnt <= '0;
    end else if (state == TRIG) begin
      trg_cnt <= trg_cnt + TRG_W'(1);
    end else begin
      trg_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      tmo_cnt <= '0;
    end else if (tmo_run) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Prescaler divides echo-high cycles by MM_TICKS; mm_cnt is the quotient.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      pre_cnt <= '0;
      mm_cnt  <= '0;
    end else if (tick_en) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        mm_cnt  <= mm_sat_inc(mm_cnt);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  assign res_new = meas_go ? mm_cnt : DST_MAX;

`ifdef ECHO_RANGER_MEDIAN_EN
  logic [11:0] hist0_p0, hist1_p0, hist2_p0;
  logic [11:0] dst_p1;
  logic        vld_p1;

  function automatic logic [11:0] median3(input logic [11:0] a,
                                          input logic [11:0] b,
                                          input logic [11:0] c);
    logic [11:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Stage p0: raw result shifts into the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_p0 <= DST_MAX;
      hist1_p0 <= DST_MAX;
      hist2_p0 <= DST_MAX;
      vld_p0   <= 1'b0;
      no_echo  <= 1'b0;
    end else begin
      vld_p0 <= meas_go | tmo_go;
      if (meas_go || tmo_go) begin
        hist0_p0 <= res_new;
        hist1_p0 <= hist0_p0;
        hist2_p0 <= hist1_p0;
        no_echo  <= tmo_go;
      end
    end
  end

  // Stage p1: registered median of the three most recent results.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_p1 <= DST_MAX;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) dst_p1 <= median3(hist0_p0, hist1_p0, hist2_p0);
    end
  end

  assign binary_dst = dst_p1;
  assign dst_valid  = vld_p1;
`else
  logic [11:0] res_p0;

  // Stage p0: raw result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p0  <= DST_MAX;
      vld_p0  <= 1'b0;
      no_echo <= 1'b0;
    end else begin
      vld_p0 <= meas_go | tmo_go;
      if (meas_go || tmo_go) begin
        res_p0  <= res_new;
        no_echo <= tmo_go;
      end
    end
  end

  assign binary_dst = res_p0;
  assign dst_valid  = vld_p0;
`endif

endmodule
